clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter DIV_W, default 32: divisor and counter width, range 2..32.
REQ-003 Parameter DEF_DIV, default 0: divisor loaded into every channel at reset.
REQ-004 Port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port wr_en  input  1  configuration write strobe, sampled each rising edge.
REQ-007 Port wr_ch  input  max(1,clog2(NCH))  channel index of the write.
REQ-008 Port wr_div  input  DIV_W  new divisor D for the channel.
REQ-009 Port wr_mode  input  1  new mode: 0 = tick, 1 = square.
REQ-010 Port ch_en  input  NCH  per-channel run enable.
REQ-011 Port tick  output  NCH  registered one-cycle pulse per channel at each terminal count.
REQ-012 Port clkout  output  NCH  registered per-channel output: equals tick in tick mode, 50% square wave in square mode.
REQ-013 Port pending  output  NCH  high while a written configuration awaits application.

Function
REQ-014 Each channel SHALL hold: counter cnt (DIV_W), active divisor/mode, shadow divisor/mode, pending flag, square phase bit.
REQ-015 While ch_en[i]=1, cnt SHALL increment each edge; when cnt==active D, cnt SHALL wrap to 0 (terminal count, TC).
REQ-016 At TC, tick[i] SHALL be 1 for the following cycle only; otherwise tick[i]=0. Tick period is D+1 cycles.
REQ-017 D=0 SHALL give tick[i] continuously high while enabled, from one cycle after the first enabled edge.
REQ-018 D SHALL be unsigned. D = 2^DIV_W-1 SHALL be legal, with no overflow beyond the wrap at TC.
REQ-019 In square mode, the phase bit SHALL toggle at each TC, and clkout[i] SHALL equal the phase bit (period 2(D+1), duty exactly 50%).
REQ-020 In tick mode, clkout[i] SHALL equal tick[i]. The phase bit SHALL be held 0 in tick mode.
REQ-021 A write (wr_en=1, wr_ch<NCH) SHALL load the shadow divisor/mode of channel wr_ch and set pending[wr_ch]=1 on that edge.
REQ-022 Writes with wr_ch>=NCH SHALL be ignored, with no state change.
REQ-023 A later write before application SHALL overwrite the shadow (last write wins).
REQ-024 A pending configuration SHALL be applied only at a TC of that channel: active<=shadow, cnt<=0, pending<=0. This guarantees no truncated period or glitch on clkout.
REQ-025 When a mode change is applied, the phase bit SHALL be cleared to 0.
REQ-026 Write and TC in the same cycle on the same channel: the TC SHALL apply the previous shadow if pending was set. The new write SHALL land in the shadow, leaving pending=1 for the next TC.
REQ-027 While ch_en[i]=0: cnt, tick[i], clkout[i] and the phase bit SHALL be held at 0. A pending configuration SHALL be applied on that edge, with pending cleared.
REQ-028 A falling ch_en SHALL force outputs to 0 on the next edge, regardless of phase.
REQ-029 Channels SHALL be fully independent and share only the write port.

Reset
REQ-030 When rst=1 at an edge, all channels SHALL be set to: cnt=0, active and shadow D=DEF_DIV, mode=tick, phase=0, pending=0, tick=0, clkout=0.
REQ-031 rst SHALL override wr_en and ch_en in the same cycle.
REQ-032 rst asserted mid-period or with pending set SHALL discard the pending configuration.
REQ-033 After rst deasserts, an enabled channel SHALL restart counting from cnt=0.

Verification
REQ-034 Tick mode, D=2, ch_en=1 after reset -> first tick three cycles after enable, then one-cycle pulses every 3 cycles.
REQ-035 Square mode, D=4 -> clkout high 5 cycles, low 5 cycles, repeating. tick pulses every 5 cycles.
REQ-036 Running D=9; write D=1 at cnt=3 -> pending=1 until cnt reaches 9; the TC period is exactly 10 cycles; afterwards the period is 2, and pending returns to 0.
REQ-037 Write and TC coincide, old pending D=5, new D=7 -> D=5 applied at that TC; D=7 applied at the following TC; pending stays 1 in between.
REQ-038 Disable ch_en mid-square-high -> clkout=0 next edge; re-enable -> counts from 0 with a full-length first half period.
REQ-039 NCH=4: write with wr_ch=3 -> only channel 3 changes. rst asserted with pending on ch1 -> all outputs 0, D=DEF_DIV, pending=0.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one configuration write port.
// Each channel emits a terminal-count tick and either a tick-follower or a 50% square clkout.
module clk_div_bank #(
   parameter int               NCH     = 4,
   parameter int               DIV_W   = 32,
   parameter logic [DIV_W-1:0] DEF_DIV = '0,
   localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [DIV_W-1:0] wr_div,
   input  logic             wr_mode,
   input  logic [NCH-1:0]   ch_en,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   clkout,
   output logic [NCH-1:0]   pending
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic [DIV_W-1:0] act_div_reg, act_div_next;
      logic [DIV_W-1:0] sh_div_reg, sh_div_next;
      logic             act_mode_reg, act_mode_next;
      logic             sh_mode_reg, sh_mode_next;
      logic             pend_reg, pend_next;
      logic             phase_reg, phase_next;
      logic             tick_reg, tick_next;
      logic             clkout_reg, clkout_next;
      logic             wr_hit;
      logic             tc;

      // Out-of-range channel indices never match any generated channel, so they are dropped.
      assign wr_hit = wr_en && (wr_ch == CH_W'(gi));
      assign tc     = (cnt_reg == act_div_reg);

      always_comb begin
         cnt_next      = cnt_reg;
         act_div_next  = act_div_reg;
         act_mode_next = act_mode_reg;
         sh_div_next   = sh_div_reg;
         sh_mode_next  = sh_mode_reg;
         pend_next     = pend_reg;
         phase_next    = phase_reg;
         tick_next     = 1'b0;

         if (!ch_en[gi]) begin
            cnt_next   = '0;
            phase_next = 1'b0;
            if (pend_reg) begin
               act_div_next  = sh_div_reg;
               act_mode_next = sh_mode_reg;
               pend_next     = 1'b0;
            end
         end else if (tc) begin
            cnt_next  = '0;
            tick_next = 1'b1;
            // A mode switch restarts the square wave low; otherwise square mode toggles.
            if (pend_reg && (sh_mode_reg != act_mode_reg))
               phase_next = 1'b0;
            else
               phase_next = act_mode_reg & ~phase_reg;
            if (pend_reg) begin
               act_div_next  = sh_div_reg;
               act_mode_next = sh_mode_reg;
               pend_next     = 1'b0;
            end
         end else begin
            cnt_next = cnt_reg + DIV_W'(1);
         end

         // A write landing together with an application refills the shadow for the next TC.
         if (wr_hit) begin
            sh_div_next  = wr_div;
            sh_mode_next = wr_mode;
            pend_next    = 1'b1;
         end

         clkout_next = act_mode_next ? phase_next : tick_next;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg      <= '0;
            act_div_reg  <= DEF_DIV;
            act_mode_reg <= 1'b0;
            sh_div_reg   <= DEF_DIV;
            sh_mode_reg  <= 1'b0;
            pend_reg     <= 1'b0;
            phase_reg    <= 1'b0;
            tick_reg     <= 1'b0;
            clkout_reg   <= 1'b0;
         end else begin
            cnt_reg      <= cnt_next;
            act_div_reg  <= act_div_next;
            act_mode_reg <= act_mode_next;
            sh_div_reg   <= sh_div_next;
            sh_mode_reg  <= sh_mode_next;
            pend_reg     <= pend_next;
            phase_reg    <= phase_next;
            tick_reg     <= tick_next;
            clkout_reg   <= clkout_next;
         end
      end

      assign tick[gi]    = tick_reg;
      assign clkout[gi]  = clkout_reg;
      assign pending[gi] = pend_reg;
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised plus scenario stimulus for clk_div_bank, checked cycle by cycle
// against a countdown-based reference model through a scoreboard queue.
module tb_clk_div_bank;
   localparam int         NCH     = 4;
   localparam int         DIV_W   = 4;
   localparam logic [3:0] DEF_DIV = 4'd3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             wr_en = 1'b0;
   logic [1:0]       wr_ch = '0;
   logic [DIV_W-1:0] wr_div = '0;
   logic             wr_mode = 1'b0;
   logic [NCH-1:0]   ch_en = '0;
   logic [NCH-1:0]   tick, clkout, pending;

   clk_div_bank #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
      .wr_mode(wr_mode), .ch_en(ch_en), .tick(tick), .clkout(clkout), .pending(pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [NCH-1:0] tk;
      logic [NCH-1:0] co;
      logic [NCH-1:0] pd;
      int             n;
   } exp_t;
   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;
   int n_cycle  = 0;

   // Reference: rem = enabled edges still to go before the terminal-count edge.
   int m_d[NCH], s_d[NCH], rem[NCH];
   bit m_sq[NCH], s_sq[NCH], pend[NCH], lvl[NCH], tk[NCH];

   task automatic model_step(input bit r, input bit we, input int ch, input int dv,
                             input bit md, input logic [NCH-1:0] en);
      exp_t e;
      for (int c = 0; c < NCH; c++) begin
         if (r) begin
            m_d[c] = int'(DEF_DIV); s_d[c] = int'(DEF_DIV); rem[c] = int'(DEF_DIV);
            m_sq[c] = 0; s_sq[c] = 0; pend[c] = 0; lvl[c] = 0; tk[c] = 0;
         end else begin
            if (!en[c]) begin
               tk[c] = 0; lvl[c] = 0;
               if (pend[c]) begin m_d[c] = s_d[c]; m_sq[c] = s_sq[c]; pend[c] = 0; end
               rem[c] = m_d[c];
            end else if (rem[c] == 0) begin
               tk[c] = 1;
               if (pend[c] && s_sq[c] != m_sq[c]) lvl[c] = 0;
               else if (m_sq[c]) lvl[c] = !lvl[c];
               if (pend[c]) begin m_d[c] = s_d[c]; m_sq[c] = s_sq[c]; pend[c] = 0; end
               rem[c] = m_d[c];
            end else begin
               tk[c] = 0;
               rem[c] = rem[c] - 1;
            end
            if (we && ch == c) begin s_d[c] = dv; s_sq[c] = md; pend[c] = 1; end
         end
         e.tk[c] = tk[c];
         e.co[c] = m_sq[c] ? lvl[c] : tk[c];
         e.pd[c] = pend[c];
      end
      e.n = n_cycle;
      sb.push_back(e);
   endtask

   task automatic cycle(input bit r, input bit we, input int ch, input int dv,
                        input bit md, input logic [NCH-1:0] en);
      @(negedge clk);
      rst = r; wr_en = we; wr_ch = 2'(ch); wr_div = DIV_W'(dv); wr_mode = md; ch_en = en;
      n_cycle++;
      model_step(r, we, ch, dv, md, en);
   endtask

   task automatic idle(input int n, input logic [NCH-1:0] en);
      for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, en);
   endtask

   // Monitor: every active edge yields one output sample, compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks += 3;
            if (tick !== e.tk) begin
               n_fail++;
               $display("FAIL tick cycle %0d: got %b expected %b", e.n, tick, e.tk);
            end
            if (clkout !== e.co) begin
               n_fail++;
               $display("FAIL clkout cycle %0d: got %b expected %b", e.n, clkout, e.co);
            end
            if (pending !== e.pd) begin
               n_fail++;
               $display("FAIL pending cycle %0d: got %b expected %b", e.n, pending, e.pd);
            end
         end
      end
   end

   initial begin
      logic [NCH-1:0] en_v;
      int waited;
      // Reset
      for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0, 0, '0);
      idle(2, '0);
      // Tick mode D=2 on ch0, applied while disabled, then enabled
      cycle(0, 1, 0, 2, 0, 4'b0000);
      idle(1, 4'b0000);
      idle(12, 4'b0001);
      // Square D=4 written while running, applied at the next TC
      cycle(0, 1, 0, 4, 1, 4'b0001);
      idle(30, 4'b0001);
      // ch1: D=9 running, then D=1 written at cnt=3
      cycle(0, 1, 1, 9, 0, 4'b0001);
      idle(1, 4'b0001);
      idle(3, 4'b0011);
      cycle(0, 1, 1, 1, 0, 4'b0011);
      idle(16, 4'b0011);
      // ch2: write coinciding with TC while a previous write is pending (D=0 -> TC every edge)
      cycle(0, 1, 2, 0, 0, 4'b0011);
      idle(1, 4'b0011);
      idle(2, 4'b0111);
      cycle(0, 1, 2, 5, 0, 4'b0111);
      cycle(0, 1, 2, 7, 0, 4'b0111);
      idle(20, 4'b0111);
      // Disable ch0 mid square-high, then re-enable
      idle(6, 4'b0111);
      idle(2, 4'b0110);
      idle(20, 4'b0111);
      // Channel-3-only write, max divisor in square mode
      cycle(0, 1, 3, 15, 1, 4'b0111);
      idle(1, 4'b0111);
      idle(40, 4'b1111);
      // Reset with pending set on ch1, while writing and enabled
      cycle(0, 1, 1, 6, 1, 4'b1111);
      cycle(1, 1, 1, 2, 1, 4'b1111);
      idle(10, 4'b1111);
      // Randomised traffic
      en_v = 4'b1111;
      for (int k = 0; k < 2500; k++) begin
         bit r, we, md;
         int ch, dv;
         r  = ($urandom_range(199) == 0);
         we = ($urandom_range(4) == 0);
         ch = $urandom_range(NCH - 1);
         dv = ($urandom_range(15) == 0) ? 15 : $urandom_range(4);
         md = $urandom_range(1);
         for (int c = 0; c < NCH; c++)
            if ($urandom_range(39) == 0) en_v[c] = ~en_v[c];
         cycle(r, we, ch, dv, md, en_v);
      end
      idle(3, en_v);
      waited = 0;
      while (sb.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d samples left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
